// File: rtl/pipe_intr_if_stage_fpu_pkg.sv
// Shared encodings for the FPU pipeline fetch stage: redirect selectors,
// fetch FSM states and the reset/nop instruction word.
package pipe_intr_if_stage_fpu_pkg;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  localparam logic [1:0] SELPC_NPC = 2'b00;
  localparam logic [1:0] SELPC_EPC = 2'b01;
  localparam logic [1:0] SELPC_EXC = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    S_REQ = 1'b0,
    S_BUF = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pipe_intr_if_stage_fpu_npc_select.sv
// Next-PC priority mux: exception/eret selection overrides the ID redirect.
module pipe_intr_if_stage_fpu_npc_select
  import pipe_intr_if_stage_fpu_pkg::*;
#(
  parameter logic [31:0] EXC_BASE = 32'h0000_0008
) (
  input  logic [1:0]  selpc_i,
  input  logic [1:0]  pcsource_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] bpc_i,
  input  logic [31:0] jpc_i,
  input  logic [31:0] da_i,
  input  logic [31:0] epc_i,
  output logic [31:0] npc_o
);

  always_comb begin
    npc_o = pc4_i;
    case (selpc_i)
      SELPC_EPC: npc_o = epc_i;
      SELPC_EXC: npc_o = EXC_BASE;
      default: begin
        // selpc=11 is reserved and falls through to the normal redirect
        case (pcsource_i)
          PCS_BR:  npc_o = bpc_i;
          PCS_JR:  npc_o = da_i;
          PCS_J:   npc_o = jpc_i;
          default: npc_o = pc4_i;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/pipe_intr_if_stage_fpu.sv
// Instruction-fetch stage with IF/ID register. Owns the PC, fetches over a
// req/ack memory port and parks one word when ID stalls.
module pipe_intr_if_stage_fpu
  import pipe_intr_if_stage_fpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_BASE = 32'h0000_0008
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   pcsource,
  input  logic [31:0]  bpc,
  input  logic [31:0]  jpc,
  input  logic [31:0]  da,
  input  logic [1:0]   selpc,
  input  logic [31:0]  epc,
  input  logic         wpcir,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_ack,
  output logic [31:0]  pc,
  output logic [31:0]  pc4_out,
  output logic [31:0]  pcd,
  output logic [31:0]  inst,
  output logic         fstall,
  output fetch_state_e state_dbg
);

  // Handshake: a fetch completes on a rising edge where imem_req=1 and
  // imem_ack=1; imem_rdata is only meaningful then. ack with req=0 is ignored.
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pcd_q, pcd_d;
  logic [31:0]  pc4_q, pc4_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  pc4, npc;

  assign pc4 = pc_q + 32'd4;

  pipe_intr_if_stage_fpu_npc_select #(
    .EXC_BASE (EXC_BASE)
  ) u_npc (
    .selpc_i    (selpc),
    .pcsource_i (pcsource),
    .pc4_i      (pc4),
    .bpc_i      (bpc),
    .jpc_i      (jpc),
    .da_i       (da),
    .epc_i      (epc),
    .npc_o      (npc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcd_d   = pcd_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    buf_d   = buf_q;
    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          if (wpcir) begin
            inst_d = imem_rdata;
            pcd_d  = pc_q;
            pc4_d  = pc4;
            pc_d   = npc;
          end else begin
            buf_d   = imem_rdata;
            state_d = S_BUF;
          end
        end
      end
      S_BUF: begin
        if (wpcir) begin
          inst_d  = buf_q;
          pcd_d   = pc_q;
          pc4_d   = pc4;
          pc_d    = npc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      pcd_q   <= 32'h0;
      pc4_q   <= 32'h0;
      inst_q  <= NOP;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcd_q   <= pcd_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      buf_q   <= buf_d;
    end
  end

  assign imem_req  = rst_n && (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign fstall    = rst_n && (state_q == S_REQ) && !imem_ack;
  assign pc        = pc_q;
  assign pc4_out   = pc4_q;
  assign pcd       = pcd_q;
  assign inst      = inst_q;
  assign state_dbg = state_q;

endmodule

// File: doc/pipe_intr_if_stage_fpu.md
Name: pipe_intr_IF_stage_fpu

Overview:
Instruction-fetch stage and IF/ID pipeline register of the interrupt-capable FPU pipeline. It sits directly upstream of the ID stage.
- Owns the PC and computes the next PC from the ID stage's redirect controls (pcsource, selpc, bpc, jpc, da, epc).
- Fetches over a req/ack instruction-memory handshake.
- Buffers a fetched word when ID stalls.
- Delivers inst, pc4 and pc to ID. Delayed-branch architecture: no flush of the fetched slot.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
EXC_BASE, 32'h0000_0008, exception/interrupt handler entry (selpc=2'b10).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
pcsource  in  2  from ID: 00 pc+4, 01 bpc, 10 da (jr), 11 jpc
bpc  in  32  branch target from ID
jpc  in  32  jump target from ID
da  in  32  forwarded rs value from ID (jr target)
selpc  in  2  from ID: 00 normal npc, 01 epc, 10 EXC_BASE, 11 reserved (treated as 00)
epc  in  32  EPC register value (eret target)
wpcir  in  1  1 = ID can accept (advance PC and IF/ID), 0 = ID stalled
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  fetched word, valid when imem_ack=1
imem_ack  in  1  fetch complete this cycle; ignored unless imem_req=1
pc  out  32  current fetch PC (to ID for selepc)
pc4_out  out  32  IF/ID registered pc+4 of instruction in ID
pcd  out  32  IF/ID registered PC of instruction in ID
inst  out  32  IF/ID registered instruction
fstall  out  1  1 = no new instruction this cycle; ID must hold, and ID/EXE (top level) must insert a bubble

Behaviour:
- Reset (rst_n=0 at edge): pc<=RESET_PC, state<=S_REQ, inst<=0 (nop), pcd<=0, pc4_out<=0, buffer<=0.
  - imem_req forced 0 while rst_n=0.
  - Any ack in flight is dropped; memory may not ack a request after req falls.
- pc4 = pc+32'd4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- npc:
  - selpc=01 -> epc; selpc=10 -> EXC_BASE.
  - Otherwise by pcsource: 00 pc4, 01 bpc, 10 da, 11 jpc.
  - npc is combinational, sampled only at an advance edge.
- FSM S_REQ: imem_req=1, imem_addr=pc.
  - ack=1 & wpcir=1: inst<=imem_rdata, pcd<=pc, pc4_out<=pc4, pc<=npc; stay S_REQ ("advance").
  - ack=1 & wpcir=0: buffer<=imem_rdata; go S_BUF. pc and IF/ID unchanged.
  - ack=0: pc and IF/ID unchanged, fstall=1.
- FSM S_BUF: imem_req=0.
  - wpcir=1: inst<=buffer, pcd<=pc, pc4_out<=pc4, pc<=npc; go S_REQ.
  - wpcir=0: hold everything.
- fstall = (state==S_REQ & ~imem_ack). fstall=0 in S_BUF, and 0 during reset.
- Ordering with the delayed branch:
  - Branch/jump in ID redirects on the same advance edge that latches its delay-slot word.
  - If the delay-slot fetch waits, the branch stays in ID (fstall) and redirects at the eventual advance.
- Exceptions:
  - selpc!=00 redirects at the next advance edge.
  - Cancelling the delay-slot word is handled downstream by the cancel flag, not here.
- Zero-wait memory (ack same cycle as req): one instruction per cycle.
- Reset has priority over every other event.

Decomposition:
- Shared package:
  - pcsource encodings PCS_PC4, PCS_BR, PCS_JR, PCS_J.
  - selpc encodings SELPC_NPC, SELPC_EPC, SELPC_EXC.
  - fetch state enum {S_REQ, S_BUF}.
  - NOP constant 32'h0.
- One sub-module, npc_select: purely combinational priority mux from selpc/pcsource/pc4/bpc/jpc/da/epc to npc.

Test Plan:
- Reset then zero-wait memory returning word=addr, wpcir=1, pcsource=00:
  - Cycles 1-3: pcd=0,4,8; inst=0,4,8; imem_addr 4,8,12; fstall=0.
- Memory acks 2 cycles late on addr 4:
  - fstall=1 for 2 cycles; pc stays 4, inst holds the word from 0.
  - Advance on the ack cycle.
- ack with wpcir=0 for 3 cycles:
  - state S_BUF, imem_req=0, fstall=0.
  - On wpcir=1, inst=buffered word, pc<=pc+4, then req resumes.
- Branch in ID (pcsource=01, bpc=32'h100) while delay slot at pc=8 acks:
  - pcd=8 latched, next imem_addr=32'h100.
  - Repeat with 1-cycle late ack; redirect must still go to 32'h100.
- selpc=10 with pcsource=11, jpc=32'h400: next pc=32'h8. Then selpc=01, epc=32'h1234: next pc=32'h1234. Then jr with da=32'hFFFF_FFFC: pc4 wraps to 0.
- Reset asserted mid-wait (S_REQ, no ack) and mid-S_BUF: all outputs return to reset values next edge, and a late ack with req=0 is ignored.
